// File: rtl/sym_ex_monitor.sv
// Observes a one-hot program location stream and issues a PASS/FAIL/ERROR verdict,
// with a location-index trace FIFO. Optional (x+y)==4 data check under SYM_MON_SUM_CHECK_EN.
module sym_ex_monitor #(
  parameter int W           = 8,
  parameter int TRACE_DEPTH = 8,
  parameter int MAX_STEPS   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   loc,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic         verdict_valid,
  input  logic         verdict_ready,
  output logic [1:0]   verdict_code,
  output logic [7:0]   step_count,
  input  logic         trace_rd_en,
  output logic [2:0]   trace_data,
  output logic         trace_empty,
  output logic         trace_ovf
);

  localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  prev_loc_reg, prev_loc_next;
  logic [7:0]  step_reg, step_next;
  logic [1:0]  code_reg, code_next;

  logic [2:0]  mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;

  logic        fifo_clear, push_req, push_ok, pop, full;
  logic [2:0]  push_idx, loc_idx;
  logic        one_hot;
  logic [1:0]  pass_code, fail_code;

  always_comb begin
    loc_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (loc[i]) loc_idx = 3'(i);
    end
  end

  assign one_hot = (loc != 8'h00) && ((loc & (loc - 8'd1)) == 8'h00);

`ifdef SYM_MON_SUM_CHECK_EN
  logic [W-1:0] sum;
  logic         sum_is_four;
  logic         unused_z;
  assign sum         = x + y;
  assign sum_is_four = (sum == W'(4));
  assign pass_code   = sum_is_four ? 2'b11 : 2'b01;
  assign fail_code   = sum_is_four ? 2'b10 : 2'b11;
  assign unused_z    = ^z;
`else
  logic unused_data;
  assign unused_data = ^{x, y, z};
  assign pass_code   = 2'b01;
  assign fail_code   = 2'b10;
`endif

  always_comb begin
    state_next    = state_reg;
    prev_loc_next = prev_loc_reg;
    step_next     = step_reg;
    code_next     = code_reg;
    fifo_clear    = 1'b0;
    push_req      = 1'b0;
    push_idx      = loc_idx;
    case (state_reg)
      IDLE: begin
        if (loc == 8'h01) begin
          fifo_clear    = 1'b1;
          push_idx      = 3'd0;
          prev_loc_next = loc;
          step_next     = 8'd0;
          code_next     = 2'b00;
          state_next    = TRACK;
        end
      end
      TRACK: begin
        // A non-one-hot location has no index, so it is never traced.
        if (!one_hot) begin
          code_next  = 2'b11;
          state_next = DONE;
        end else if (loc != prev_loc_reg) begin
          push_req      = 1'b1;
          prev_loc_next = loc;
          step_next     = (step_reg == 8'hFF) ? step_reg : step_reg + 8'd1;
          if (loc == 8'h40) begin
            code_next  = pass_code;
            state_next = DONE;
          end else if (loc == 8'h80) begin
            code_next  = fail_code;
            state_next = DONE;
          end else if (({1'b0, step_reg} + 9'd1) >= 9'(MAX_STEPS)) begin
            code_next  = 2'b11;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (verdict_ready) begin
          code_next  = 2'b00;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      prev_loc_reg <= 8'h00;
      step_reg     <= 8'd0;
      code_reg     <= 2'b00;
    end else begin
      state_reg    <= state_next;
      prev_loc_reg <= prev_loc_next;
      step_reg     <= step_next;
      code_reg     <= code_next;
    end
  end

  assign full    = (count_reg == (AW+1)'(TRACE_DEPTH));
  assign pop     = trace_rd_en && (count_reg != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (fifo_clear) begin
      wr_ptr_reg <= AW'(1);
      rd_ptr_reg <= '0;
      count_reg  <= (AW+1)'(1);
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (!push_ok && pop) count_reg <= count_reg - (AW+1)'(1);
      if (push_req && !push_ok) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_clear)   mem[0] <= 3'd0;
    else if (push_ok) mem[wr_ptr_reg] <= push_idx;
  end

  assign trace_empty   = (count_reg == '0);
  assign trace_data    = trace_empty ? 3'd0 : mem[rd_ptr_reg];
  assign trace_ovf     = ovf_reg;
  assign verdict_valid = (state_reg == DONE);
  assign verdict_code  = verdict_valid ? code_reg : 2'b00;
  assign step_count    = step_reg;

endmodule

// File: tb/tb_sym_ex_monitor.sv
// Directed bench for sym_ex_monitor: vector table for a PASS run plus hand-written
// sequences for error, timeout/overflow, sum-check FAIL and mid-run reset.
module tb_sym_ex_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] loc;
  logic [7:0] x, y, z;
  logic       verdict_valid, verdict_ready;
  logic [1:0] verdict_code;
  logic [7:0] step_count;
  logic       trace_rd_en;
  logic [2:0] trace_data;
  logic       trace_empty, trace_ovf;

  int errors = 0;
  int checks = 0;

  sym_ex_monitor #(.W(8), .TRACE_DEPTH(8), .MAX_STEPS(16)) dut (
    .clk(clk), .rst_n(rst_n), .loc(loc), .x(x), .y(y), .z(z),
    .verdict_valid(verdict_valid), .verdict_ready(verdict_ready),
    .verdict_code(verdict_code), .step_count(step_count),
    .trace_rd_en(trace_rd_en), .trace_data(trace_data),
    .trace_empty(trace_empty), .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] loc;
    logic       rd;
    logic       rdy;
    logic       ev;
    logic [1:0] ec;
    logic [7:0] es;
    logic       ee;
    logic       eo;
    logic [2:0] ed;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [7:0] l, input logic rd, input logic rdy,
                              input logic ev, input logic [1:0] ec, input logic [7:0] es,
                              input logic ee, input logic eo, input logic [2:0] ed);
    vec_t v;
    v.loc = l; v.rd = rd; v.rdy = rdy; v.ev = ev; v.ec = ec;
    v.es = es; v.ee = ee; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"}, verdict_valid, 0);
    chk({tag, " code"},  verdict_code, 0);
    chk({tag, " step"},  step_count, 0);
    chk({tag, " empty"}, trace_empty, 1);
    chk({tag, " ovf"},   trace_ovf, 0);
    chk({tag, " data"},  trace_data, 0);
  endtask

  int exp_trace [8] = '{0, 1, 2, 1, 2, 1, 2, 1};

  initial begin
    rst_n = 1'b0; loc = 8'h00; x = 8'd0; y = 8'd0; z = 8'd0;
    verdict_ready = 1'b0; trace_rd_en = 1'b0;

    // PASS run 01..40 followed by draining the trace
    tbl[0]  = mk(8'h01, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mk(8'h02, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    tbl[2]  = mk(8'h04, 0, 0, 0, 2'b00, 2, 0, 0, 0);
    tbl[3]  = mk(8'h08, 0, 0, 0, 2'b00, 3, 0, 0, 0);
    tbl[4]  = mk(8'h10, 0, 0, 0, 2'b00, 4, 0, 0, 0);
    tbl[5]  = mk(8'h20, 0, 0, 0, 2'b00, 5, 0, 0, 0);
    tbl[6]  = mk(8'h40, 0, 0, 1, 2'b01, 6, 0, 0, 0);
    tbl[7]  = mk(8'h40, 1, 0, 1, 2'b01, 6, 0, 0, 1);
    tbl[8]  = mk(8'h00, 1, 0, 1, 2'b01, 6, 0, 0, 2);
    tbl[9]  = mk(8'h00, 1, 0, 1, 2'b01, 6, 0, 0, 3);
    tbl[10] = mk(8'h00, 1, 0, 1, 2'b01, 6, 0, 0, 4);
    tbl[11] = mk(8'h00, 1, 0, 1, 2'b01, 6, 0, 0, 5);
    tbl[12] = mk(8'h00, 1, 0, 1, 2'b01, 6, 0, 0, 6);
    tbl[13] = mk(8'h00, 1, 0, 1, 2'b01, 6, 1, 0, 0);
    tbl[14] = mk(8'h00, 0, 1, 0, 2'b00, 6, 1, 0, 0);
    tbl[15] = mk(8'h00, 1, 0, 0, 2'b00, 6, 1, 0, 0);

    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      loc = tbl[i].loc; trace_rd_en = tbl[i].rd; verdict_ready = tbl[i].rdy;
      tick();
      $display("vec %0d: loc=%h rd=%0d rdy=%0d -> valid=%0d code=%0d step=%0d empty=%0d ovf=%0d data=%0d",
               i, loc, trace_rd_en, verdict_ready, verdict_valid, verdict_code,
               step_count, trace_empty, trace_ovf, trace_data);
      chk($sformatf("vec%0d valid", i), verdict_valid, tbl[i].ev);
      chk($sformatf("vec%0d code", i),  verdict_code,  tbl[i].ec);
      chk($sformatf("vec%0d step", i),  step_count,    tbl[i].es);
      chk($sformatf("vec%0d empty", i), trace_empty,   tbl[i].ee);
      chk($sformatf("vec%0d ovf", i),   trace_ovf,     tbl[i].eo);
      chk($sformatf("vec%0d data", i),  trace_data,    tbl[i].ed);
    end
    trace_rd_en = 1'b0; verdict_ready = 1'b0;

    // Timeout run with trace overflow
    loc = 8'h01; tick();
    for (int i = 1; i <= 20; i++) begin
      loc = (i % 2 == 1) ? 8'h02 : 8'h04;
      tick();
      $display("timeout step %0d: loc=%h valid=%0d code=%0d step=%0d ovf=%0d",
               i, loc, verdict_valid, verdict_code, step_count, trace_ovf);
      chk($sformatf("to%0d step", i),  step_count, (i <= 16) ? i : 16);
      chk($sformatf("to%0d valid", i), verdict_valid, (i >= 16) ? 1 : 0);
      chk($sformatf("to%0d ovf", i),   trace_ovf, (i >= 8) ? 1 : 0);
    end
    chk("to code", verdict_code, 3);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to pop%0d empty", k), trace_empty, 0);
      chk($sformatf("to pop%0d data", k), trace_data, exp_trace[k]);
      trace_rd_en = 1'b1; tick(); trace_rd_en = 1'b0;
      $display("timeout pop %0d: data=%0d empty=%0d", k, trace_data, trace_empty);
    end
    chk("to drained empty", trace_empty, 1);
    verdict_ready = 1'b1; loc = 8'h00; tick(); verdict_ready = 1'b0;
    $display("timeout ack: valid=%0d ovf=%0d", verdict_valid, trace_ovf);
    chk("to ack valid", verdict_valid, 0);
    chk("to ovf sticky in idle", trace_ovf, 1);

    // Non-one-hot error with consumer stalled
    loc = 8'h01; tick();
    $display("err start: ovf=%0d empty=%0d step=%0d", trace_ovf, trace_empty, step_count);
    chk("err start ovf cleared", trace_ovf, 0);
    chk("err start empty", trace_empty, 0);
    chk("err start step", step_count, 0);
    loc = 8'h03; tick();
    for (int k = 0; k < 5; k++) begin
      $display("err hold %0d: valid=%0d code=%0d", k, verdict_valid, verdict_code);
      chk($sformatf("err hold%0d valid", k), verdict_valid, 1);
      chk($sformatf("err hold%0d code", k), verdict_code, 3);
      loc = (k % 2 == 0) ? 8'h40 : 8'h80;
      tick();
    end
    chk("err step", step_count, 0);
    verdict_ready = 1'b1; tick(); verdict_ready = 1'b0;
    $display("err ack: valid=%0d code=%0d", verdict_valid, verdict_code);
    chk("err ack valid", verdict_valid, 0);
    chk("err ack code", verdict_code, 0);

    // FAIL location with x+y == 4
    x = 8'd3; y = 8'd1; loc = 8'h00; tick();
    loc = 8'h01; tick();
    loc = 8'h02; tick();
    loc = 8'h04; tick();
    loc = 8'h20; tick();
    chk("fail pre valid", verdict_valid, 0);
    loc = 8'h80; tick();
    $display("fail run: valid=%0d code=%0d step=%0d", verdict_valid, verdict_code, step_count);
    chk("fail valid", verdict_valid, 1);
    chk("fail code", verdict_code, 2);
    chk("fail step", step_count, 4);
    verdict_ready = 1'b1; loc = 8'h00; tick(); verdict_ready = 1'b0;
    chk("fail ack valid", verdict_valid, 0);

    // Reset mid-run
    x = 8'd0; y = 8'd0;
    loc = 8'h01; tick();
    loc = 8'h02; tick();
    loc = 8'h04; tick();
    loc = 8'h08; tick();
    chk("rst pre step", step_count, 3);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-run reset: valid=%0d code=%0d step=%0d empty=%0d ovf=%0d",
             verdict_valid, verdict_code, step_count, trace_empty, trace_ovf);
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      loc = 8'h40; tick();
      chk($sformatf("post rst%0d valid", k), verdict_valid, 0);
      chk($sformatf("post rst%0d step", k), step_count, 0);
      chk($sformatf("post rst%0d empty", k), trace_empty, 1);
    end
    loc = 8'h01; tick();
    chk("restart empty", trace_empty, 0);
    chk("restart data", trace_data, 0);
    loc = 8'h02; tick();
    $display("restart: valid=%0d step=%0d", verdict_valid, step_count);
    chk("restart step", step_count, 1);
    chk("restart valid", verdict_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
